// File: rtl/mux_16x1_arbiter.sv
// mux_16x1_arbiter: round-robin arbiter that time-multiplexes one mux_16x1
// datapath among 16 requesters and registers the selected bit with a valid.
//
// Optional feature macro: ARB_HOLD_EN
//   defined   - a grant lasts until req[sel] drops; SLOT_LEN has no effect
//   undefined - each grant is bounded to SLOT_LEN cycles (default)
//
// Ports:
//   clk        - clock, rising edge
//   rst        - synchronous active-high reset
//   req[15:0]  - per-requester request
//   in[15:0]   - per-requester data bit
//   gnt[15:0]  - one-hot grant (registered), zero when idle
//   sel[3:0]   - granted index (registered), drives the mux select
//   busy       - OR of gnt (registered)
//   dout       - in[sel] captured one cycle later
//   dout_valid - busy delayed one cycle, qualifies dout

// Combinational 16:1 bit selector shared by all requesters.
module mux_16x1 (
  input  logic [15:0] in,
  input  logic [3:0]  sel,
  output logic        out_c
);
  assign out_c = in[sel];
endmodule

module mux_16x1_arbiter #(
  parameter int unsigned SLOT_LEN = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] req,
  input  logic [15:0] in,
  output logic [15:0] gnt,
  output logic [3:0]  sel,
  output logic        busy,
  output logic        dout,
  output logic        dout_valid
);

  localparam int unsigned N  = 16;
  localparam int unsigned SW = 4;
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] CNT_LOAD = CW'(SLOT_LEN - 1);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t        state, state_n;
  logic [SW-1:0] ptr, ptr_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [SW-1:0] sel_n;
  logic [N-1:0]  gnt_n;
  logic          busy_n;

  logic [SW-1:0] scan_start;
  logic          win_found;
  logic [SW-1:0] win_idx;
  logic          slot_end;
  logic          mux_out;

  // First set request at or after start, wrapping 15 -> 0.
  function automatic logic [SW:0] rr_pick(input logic [N-1:0] r, input logic [SW-1:0] start);
    logic          found;
    logic [SW-1:0] idx;
    logic [SW-1:0] win;
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < int'(N); i++) begin
      idx = start + SW'(i);
      if (!found && r[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    return {found, win};
  endfunction

  // In GRANT the next pointer is sel+1, so re-arbitration scans from there
  // in the same cycle; a sole persistent requester wraps back to itself.
  always_comb begin
    scan_start           = (state == GRANT) ? (sel + SW'(1)) : ptr;
    {win_found, win_idx} = rr_pick(req, scan_start);
  end

`ifdef ARB_HOLD_EN
  assign slot_end = !req[sel];
`else
  assign slot_end = (cnt == '0) || !req[sel];
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    cnt_n   = cnt;
    sel_n   = sel;
    gnt_n   = gnt;
    case (state)
      IDLE: begin
        if (win_found) begin
          sel_n   = win_idx;
          gnt_n   = N'(1) << win_idx;
          cnt_n   = CNT_LOAD;
          state_n = GRANT;
        end
      end
      GRANT: begin
        if (!slot_end) begin
          cnt_n = cnt - CW'(1);
        end else begin
          ptr_n = sel + SW'(1);
          if (win_found) begin
            sel_n = win_idx;
            gnt_n = N'(1) << win_idx;
            cnt_n = CNT_LOAD;
          end else begin
            sel_n   = '0;
            gnt_n   = '0;
            state_n = IDLE;
          end
        end
      end
      default: begin
        sel_n   = '0;
        gnt_n   = '0;
        state_n = IDLE;
      end
    endcase
    busy_n = |gnt_n;
  end

  mux_16x1 u_mux (
    .in    (in),
    .sel   (sel),
    .out_c (mux_out)
  );

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      cnt        <= '0;
      sel        <= '0;
      gnt        <= '0;
      busy       <= 1'b0;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
    end else begin
      state      <= state_n;
      ptr        <= ptr_n;
      cnt        <= cnt_n;
      sel        <= sel_n;
      gnt        <= gnt_n;
      busy       <= busy_n;
      dout       <= mux_out;
      dout_valid <= busy;
    end
  end

endmodule
